// File: rtl/test_result_monitor_pkg.sv
// Shared types and constants for the rv32 self-check test result monitor.
package test_result_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_VERDICT = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Value the test program leaves in the pass register on success.
    localparam int unsigned PASS_VAL = 1;

    localparam int unsigned SETTLE_W = 8;

endpackage

// File: rtl/test_result_monitor_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/test_result_monitor.sv
// Snoops register-file writeback to decide pass/fail/timeout of a self-checking
// test program; verdict and status outputs are sticky until clr or reset.
module test_result_monitor
    import test_result_monitor_pkg::*;
#(
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      ADDR_W     = 5,
    parameter int unsigned      DONE_REG   = 26,
    parameter int unsigned      PASS_REG   = 27,
    parameter int unsigned      STEP_REG   = 3,
    parameter int unsigned      SETTLE_CYC = 10,
    parameter int unsigned      TMO_W      = 24,
    parameter logic [TMO_W-1:0] TMO_CYC    = 24'hFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] step,
    output logic [TMO_W-1:0]  cycles
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);

    state_e              state_q,   state_d;
    logic [SETTLE_W-1:0] settle_q,  settle_d;
    logic                tmo_q,     tmo_d;
    logic [DATA_W-1:0]   sh_pass_q, sh_pass_d;
    logic [DATA_W-1:0]   sh_step_q, sh_step_d;
    logic                done_q,    done_d;
    logic                pass_q,    pass_d;
    logic                fail_q,    fail_d;
    logic                timeout_q, timeout_d;

    logic wr_ok;
    logic wr_done;
    logic wr_pass;
    logic wr_step;
    logic tracking;
    logic tmo_hit;
    logic pass_val;

    // Index 0 is never a real destination, so it must not alias a parameter set to 0.
    assign wr_ok    = wb_we && (wb_waddr != '0);
    assign wr_done  = wr_ok && (wb_waddr == ADDR_W'(DONE_REG)) && (wb_wdata != '0);
    assign wr_pass  = wr_ok && (wb_waddr == ADDR_W'(PASS_REG));
    assign wr_step  = wr_ok && (wb_waddr == ADDR_W'(STEP_REG));
    assign tracking = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign tmo_hit  = (TMO_CYC != '0) && (cycles == (TMO_CYC - TMO_W'(1)));
    assign pass_val = (sh_pass_q == DATA_W'(PASS_VAL));

    sat_counter #(
        .W (TMO_W)
    ) u_cycles (
        .clk (clk),
        .rst (rst),
        .en  (tracking),
        .clr (clr),
        .cnt (cycles)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        sh_pass_d = sh_pass_q;
        sh_step_d = sh_step_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;

        if (tracking) begin
            if (wr_pass) sh_pass_d = wb_wdata;
            if (wr_step) sh_step_d = wb_wdata;
        end

        case (state_q)
            ST_RUN: begin
                if (wr_done) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                end else if (tmo_hit) begin
                    state_d = ST_VERDICT;
                    tmo_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_VERDICT;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_VERDICT: begin
                done_d    = 1'b1;
                pass_d    = !tmo_q && pass_val;
                fail_d    = tmo_q || !pass_val;
                timeout_d = tmo_q;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
            end
            default: state_d = ST_RUN;
        endcase

        if (clr) begin
            state_d   = ST_RUN;
            settle_d  = '0;
            tmo_d     = 1'b0;
            sh_pass_d = '0;
            sh_step_d = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            settle_q  <= '0;
            tmo_q     <= 1'b0;
            sh_pass_q <= '0;
            sh_step_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            sh_pass_q <= sh_pass_d;
            sh_step_q <= sh_step_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign done    = done_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign timeout = timeout_q;
    assign step    = sh_step_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor with a short timeout (100 cycles).
module tb_test_result_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_waddr = '0;
    logic [31:0] wb_wdata = '0;
    logic        done, pass, fail, timeout;
    logic [31:0] step;
    logic [23:0] cycles;

    int n_cmp = 0;
    int n_err = 0;

    test_result_monitor #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .DONE_REG   (26),
        .PASS_REG   (27),
        .STEP_REG   (3),
        .SETTLE_CYC (10),
        .TMO_W      (24),
        .TMO_CYC    (24'd100)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .timeout  (timeout),
        .step     (step),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
        @(negedge clk);
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic p,
                                input logic f, input logic t);
        check({tag, "_done"},    32'(done),    32'(d));
        check({tag, "_pass"},    32'(pass),    32'(p));
        check({tag, "_fail"},    32'(fail),    32'(f));
        check({tag, "_timeout"}, 32'(timeout), 32'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_step",   step,         32'd0);
        check("reset_cycles", 32'(cycles),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Pass: done exactly 11 edges after the x26 write.
        pulse_clr();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(10);
        check("pass_early_done", 32'(done), 32'd0);
        idle(1);
        check_status("pass", 1'b1, 1'b1, 1'b0, 1'b0);

        // Fail with step captured.
        pulse_clr();
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        idle(11);
        check_status("failv", 1'b1, 1'b0, 1'b1, 1'b0);
        check("failv_step", step, 32'd5);

        // Late pass write during settle is honoured.
        pulse_clr();
        wr(5'd26, 32'd1);
        idle(2);
        wr(5'd27, 32'd1);
        idle(8);
        check_status("late", 1'b1, 1'b1, 1'b0, 1'b0);

        // x0 and zero-data done writes change nothing; then a real done; HOLD ignores writes.
        pulse_clr();
        wr(5'd0, 32'hFFFF_FFFF);
        wr(5'd26, 32'd0);
        wr(5'd27, 32'd1);
        idle(14);
        check("ignore_done", 32'(done), 32'd0);
        check("ignore_cycles", 32'(cycles), 32'd17);
        wr(5'd26, 32'd7);
        idle(11);
        check_status("hold", 1'b1, 1'b1, 1'b0, 1'b0);
        wr(5'd27, 32'd0);
        wr(5'd3, 32'd9);
        wr(5'd26, 32'd1);
        idle(3);
        check_status("hold_wr", 1'b1, 1'b1, 1'b0, 1'b0);
        check("hold_step", step, 32'd0);
        check("hold_cycles", 32'(cycles), 32'd28);

        // clr out of HOLD, then a fresh pass.
        pulse_clr();
        check_status("clr", 1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_cycles", 32'(cycles), 32'd0);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(11);
        check_status("clr_pass", 1'b1, 1'b1, 1'b0, 1'b0);

        // Timeout after 100 counted cycles.
        pulse_clr();
        idle(100);
        check("tmo_early_done", 32'(done), 32'd0);
        idle(1);
        check_status("tmo", 1'b1, 1'b0, 1'b1, 1'b1);
        check("tmo_cycles", 32'(cycles), 32'd100);

        // Done write on the timeout cycle wins.
        pulse_clr();
        idle(99);
        wr(5'd26, 32'd1);
        idle(10);
        check("race_early_done", 32'(done), 32'd0);
        idle(1);
        check_status("race", 1'b1, 1'b0, 1'b1, 1'b0);
        check("race_cycles", 32'(cycles), 32'd110);

        // Reset mid-settle discards the pending verdict.
        pulse_clr();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(3);
        rst = 1'b0;
        #1;
        check_status("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_cycles", 32'(cycles), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(15);
        check("rst_after_done", 32'(done), 32'd0);
        check("rst_after_cycles", 32'(cycles), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
